// File: rtl/sie_tx_arbiter.sv
// sie_tx_arbiter: shares the SIE packet-transmit port among NREQ requesters, with a completion watchdog.
// Define SIE_TX_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module sie_tx_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   reqWEn,
    input  logic [4*NREQ-1:0] reqPID,
    output logic [NREQ-1:0]   reqBusy,
    output logic [NREQ-1:0]   reqDone,
    output logic [NREQ-1:0]   reqErr,
    output logic [NREQ-1:0]   reqOvf,
    output logic              sendPacketWEn,
    output logic [3:0]        sendPacketPID,
    input  logic              sendPacketRdy,
    output logic [2:0]        grantIdx
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t               state, state_nxt;
    logic [NREQ-1:0]      pending;
    logic [NREQ-1:0][3:0] pid_q;
    logic [TO_W-1:0]      wd;
    logic                 found_lo;
    logic [2:0]           win_lo, winner;
    logic [3:0]           win_pid;
    logic                 wd_hit, abort, grant, finish;

    // Lowest pending index; also the wrap-around fallback for round-robin.
    always_comb begin
        found_lo = 1'b0;
        win_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_lo && pending[i]) begin
                found_lo = 1'b1;
                win_lo   = 3'(i);
            end
        end
    end

`ifdef SIE_TX_RR_EN
    logic [2:0] rr_start;
    logic       found_hi;
    logic [2:0] win_hi;

    always_comb begin
        found_hi = 1'b0;
        win_hi   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_hi && pending[i] && 3'(i) >= rr_start) begin
                found_hi = 1'b1;
                win_hi   = 3'(i);
            end
        end
    end

    assign winner = found_hi ? win_hi : win_lo;

    always_ff @(posedge clk) begin
        if (rst)
            rr_start <= '0;
        else if (grant)
            rr_start <= (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
    end
`else
    assign winner = win_lo;
`endif

    always_comb begin
        win_pid = '0;
        for (int i = 0; i < NREQ; i++)
            if (winner == 3'(i)) win_pid = pid_q[i];
    end

    assign wd_hit = (wd == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A real completion seen in the same cycle as the watchdog limit is not an abort.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE:      if (found_lo && sendPacketRdy) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (wd_hit) begin
                    state_nxt = COMPLETE;
                    abort     = 1'b1;
                end else if (!sendPacketRdy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sendPacketRdy) begin
                    state_nxt = COMPLETE;
                end else if (wd_hit) begin
                    state_nxt = COMPLETE;
                    abort     = 1'b1;
                end
            end
            COMPLETE:  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign grant  = (state == IDLE) && (state_nxt == ISSUE);
    assign finish = (state == WAIT_LOW || state == WAIT_DONE) && (state_nxt == COMPLETE);

    // Busy drops on the edge into COMPLETE, so a strobe seen alongside reqDone is a fresh request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            pid_q         <= '0;
            wd            <= '0;
            reqBusy       <= '0;
            reqDone       <= '0;
            reqErr        <= '0;
            reqOvf        <= '0;
            sendPacketWEn <= 1'b0;
            sendPacketPID <= '0;
            grantIdx      <= '0;
        end else begin
            sendPacketWEn <= grant;
            reqDone       <= '0;
            reqErr        <= '0;
            if (grant) begin
                grantIdx      <= winner;
                sendPacketPID <= win_pid;
            end
            if (state == ISSUE)
                wd <= '0;
            else if (state == WAIT_LOW || state == WAIT_DONE)
                wd <= wd + 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (state == ISSUE && grantIdx == 3'(i))
                    pending[i] <= 1'b0;
                if (finish && grantIdx == 3'(i)) begin
                    reqDone[i] <= 1'b1;
                    reqErr[i]  <= abort;
                    reqBusy[i] <= 1'b0;
                end
                if (reqWEn[i]) begin
                    if (!reqBusy[i]) begin
                        pending[i] <= 1'b1;
                        pid_q[i]   <= reqPID[4*i +: 4];
                        reqBusy[i] <= 1'b1;
                    end else begin
                        reqOvf[i]  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sie_tx_arbiter.sv
// Directed bench for sie_tx_arbiter: issue timing, arbitration order, overflow, watchdog, re-request, reset.
module tb_sie_tx_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 20;
    localparam int TO_W    = 5;
    localparam int LIMIT   = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   reqWEn;
    logic [4*NREQ-1:0] reqPID;
    logic [NREQ-1:0]   reqBusy, reqDone, reqErr, reqOvf;
    logic              sendPacketWEn;
    logic [3:0]        sendPacketPID;
    logic              sendPacketRdy;
    logic [2:0]        grantIdx;
    logic              sie_hold = 1'b0;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    sie_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .reqWEn       (reqWEn),
        .reqPID       (reqPID),
        .reqBusy      (reqBusy),
        .reqDone      (reqDone),
        .reqErr       (reqErr),
        .reqOvf       (reqOvf),
        .sendPacketWEn(sendPacketWEn),
        .sendPacketPID(sendPacketPID),
        .sendPacketRdy(sendPacketRdy),
        .grantIdx     (grantIdx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_issue(output int cyc);
        cyc = 0;
        while (sendPacketWEn !== 1'b1 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        chk("issue_seen", sendPacketWEn, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (reqDone === '0 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        chk("done_seen", reqDone !== '0, 1);
    endtask

    // SIE model: Rdy drops the cycle after an issue, returns 8 cycles later unless held.
    initial begin : sie
        sendPacketRdy = 1'b1;
        forever begin
            tick();
            if (sendPacketWEn === 1'b1 && rst === 1'b0) begin
                tick();
                sendPacketRdy = 1'b0;
                repeat (8) tick();
                while (sie_hold) tick();
                sendPacketRdy = 1'b1;
            end
        end
    end

    initial begin : main
        int         cyc;
        int         ndone;
        logic [2:0] exp_idx [3];
        logic [3:0] exp_pid [3];
`ifdef SIE_TX_RR_EN
        exp_idx[0] = 3'd1; exp_pid[0] = 4'he;
        exp_idx[1] = 3'd2; exp_pid[1] = 4'h3;
        exp_idx[2] = 3'd0; exp_pid[2] = 4'ha;
`else
        exp_idx[0] = 3'd0; exp_pid[0] = 4'ha;
        exp_idx[1] = 3'd1; exp_pid[1] = 4'he;
        exp_idx[2] = 3'd2; exp_pid[2] = 4'h3;
`endif
        rst = 1'b1; reqWEn = '0; reqPID = '0;
        repeat (2) tick();
        chk("rst_busy", reqBusy, 0);
        chk("rst_done", reqDone, 0);
        chk("rst_err", reqErr, 0);
        chk("rst_ovf", reqOvf, 0);
        chk("rst_wen", sendPacketWEn, 0);
        chk("rst_pid", sendPacketPID, 0);
        chk("rst_grant", grantIdx, 0);
        rst = 1'b0;
        tick();

        // single request on index 1
        reqWEn = 3'b010; reqPID = 12'h020;
        tick();
        reqWEn = '0;
        chk("single_busy", reqBusy, 3'b010);
        chk("single_wen_early", sendPacketWEn, 0);
        tick();
        chk("single_wen", sendPacketWEn, 1);
        chk("single_pid", sendPacketPID, 4'h2);
        chk("single_grant", grantIdx, 1);
        wait_done(cyc);
        chk("single_lat", cyc, 10);
        chk("single_done", reqDone, 3'b010);
        chk("single_err", reqErr, 0);
        chk("single_busy_clr", reqBusy, 0);
        tick();
        chk("single_done_once", reqDone, 0);

        // re-request in the completion cycle
        reqWEn = 3'b001; reqPID = 12'h005;
        tick();
        reqWEn = '0;
        wait_issue(cyc);
        chk("rereq_pid1", sendPacketPID, 4'h5);
        wait_done(cyc);
        chk("rereq_done1", reqDone, 3'b001);
        reqWEn = 3'b001; reqPID = 12'h006;
        tick();
        reqWEn = '0;
        chk("rereq_ovf", reqOvf, 0);
        chk("rereq_busy", reqBusy, 3'b001);
        wait_issue(cyc);
        chk("rereq_lat", cyc, 1);
        chk("rereq_pid2", sendPacketPID, 4'h6);
        chk("rereq_grant", grantIdx, 0);
        wait_done(cyc);
        chk("rereq_done2", reqDone, 3'b001);
        tick();

        // simultaneous requests
        reqWEn = 3'b111; reqPID = 12'h3ea;
        tick();
        reqWEn = '0;
        chk("simul_busy", reqBusy, 3'b111);
        for (int k = 0; k < 3; k++) begin
            wait_issue(cyc);
            chk("simul_grant", grantIdx, exp_idx[k]);
            chk("simul_pid", sendPacketPID, exp_pid[k]);
            wait_done(cyc);
            chk("simul_done", reqDone, 3'b001 << exp_idx[k]);
            chk("simul_err", reqErr, 0);
        end
        tick();

        // overflow on index 2
        reqWEn = 3'b100; reqPID = 12'h700;
        tick();
        reqPID = 12'hb00;
        tick();
        reqWEn = '0;
        chk("ovf_flag", reqOvf, 3'b100);
        chk("ovf_wen", sendPacketWEn, 1);
        chk("ovf_pid", sendPacketPID, 4'h7);
        chk("ovf_grant", grantIdx, 2);
        wait_done(cyc);
        chk("ovf_done", reqDone, 3'b100);
        ndone = 0;
        repeat (12) begin
            tick();
            if (reqDone !== '0) ndone++;
        end
        chk("ovf_one_done", ndone, 0);
        chk("ovf_sticky", reqOvf, 3'b100);

        // watchdog abort, then the queued request is served
        sie_hold = 1'b1;
        reqWEn = 3'b011; reqPID = 12'h09c;
        tick();
        reqWEn = '0;
        wait_issue(cyc);
        chk("wd_grant", grantIdx, 0);
        chk("wd_pid", sendPacketPID, 4'hc);
        wait_done(cyc);
        chk("wd_lat", cyc, TIMEOUT + 1);
        chk("wd_done", reqDone, 3'b001);
        chk("wd_err", reqErr, 3'b001);
        sie_hold = 1'b0;
        tick();
        chk("wd_err_pulse", reqErr, 0);
        wait_issue(cyc);
        chk("wd_next_grant", grantIdx, 1);
        chk("wd_next_pid", sendPacketPID, 4'h9);
        wait_done(cyc);
        chk("wd_next_done", reqDone, 3'b010);
        chk("wd_next_err", reqErr, 0);
        tick();

        // reset while waiting for completion
        reqWEn = 3'b100; reqPID = 12'h400;
        tick();
        reqWEn = '0;
        wait_issue(cyc);
        chk("rstmid_pid", sendPacketPID, 4'h4);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", reqBusy, 0);
        chk("rstmid_done", reqDone, 0);
        chk("rstmid_wen", sendPacketWEn, 0);
        chk("rstmid_pid0", sendPacketPID, 0);
        chk("rstmid_grant", grantIdx, 0);
        chk("rstmid_ovf", reqOvf, 0);
        ndone = 0;
        repeat (12) begin
            tick();
            if (reqDone !== '0) ndone++;
        end
        chk("rstmid_no_done", ndone, 0);
        reqWEn = 3'b010; reqPID = 12'h0d0;
        tick();
        reqWEn = '0;
        wait_issue(cyc);
        chk("rstmid_new_lat", cyc, 1);
        chk("rstmid_new_pid", sendPacketPID, 4'hd);
        chk("rstmid_new_grant", grantIdx, 1);
        wait_done(cyc);
        chk("rstmid_new_done", reqDone, 3'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
